axi4_read_burst_engine: RTL and testbench
=========================================

Name: axi4_read_burst_engine

Overview:
- Consumes AR commands from the read-side AR FIFO of the AXI4 slave front end and performs each burst as single-beat reads on a simple memory port.
- Writes each returned beat, with rid/rlast/rresp, into the R FIFO of the same front end.
- Sits directly downstream of the slave-to-FIFO stage, between its AR/R FIFOs and local memory or registers.

Parameters:
- A, 32, address width
- N, 8, data bus width in bytes; power of 2
- I, 1, ID width

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous active-low
- ar_rd_empty  in  1  AR FIFO empty
- ar_rd_en  out  1  AR FIFO pop; show-ahead FIFO, so head data is valid while ~ar_rd_empty
- araddr  in  A  head-of-FIFO start address
- arburst  in  2  0=FIXED, 1=INCR, 2=WRAP, 3=reserved
- arid  in  I  transaction ID
- arlen  in  8  beats-1
- arsize  in  3  log2 bytes per beat
- r_wr_full  in  1  R FIFO full
- r_wr_en  out  1  R FIFO push
- rdata  out  8N  beat data
- rid  out  I  echoed arid
- rlast  out  1  final beat
- rresp  out  2  0=OKAY, 2=SLVERR
- mem_rd_en  out  1  memory read request, one cycle
- mem_addr  out  A  memory address, byte address
- mem_rd_data  in  8N  memory read data
- mem_rd_valid  in  1  read data valid; latency >=1 cycle, variable

Behaviour:
- Clocking/reset: single clock domain (aclk); reset is asynchronous active-low (aresetn).
- Reset: state=IDLE. ar_rd_en, r_wr_en, mem_rd_en, rlast = 0; rdata, rid, rresp, mem_addr = 0.
- Reset mid-burst: aborts the burst. Outstanding mem response is dropped; the memory is reset by the same aresetn.

States:
- IDLE: if ~ar_rd_empty, pulse ar_rd_en for one cycle and latch addr, burst, id, len, size. Set beat_cnt=0 and compute err. Next state BEAT.
- BEAT:
  - Wait while r_wr_full.
  - If err: push a beat (r_wr_en=1, rresp=SLVERR, rdata=0) with no mem access. Go to IDLE if last, else stay in BEAT.
  - Otherwise: mem_rd_en=1, mem_addr=cur_addr; go to WAIT.
- WAIT:
  - On mem_rd_valid, r_wr_en=1 in the same cycle, rdata=mem_rd_data, rresp=OKAY.
  - Advance cur_addr and beat_cnt. Go to IDLE if last, else BEAT.
  - mem_rd_valid in any other state is ignored.
- Single outstanding read. No overflow is possible because only this block writes the R FIFO, so full can only fall between issue and push.
- rlast=1 iff beat_cnt==len. rid=latched id on every beat.
- Minimum latency: AR pop to first R push = 3 cycles with 1-cycle memory. Sustained rate is 1 beat per 2 cycles.
- Back-to-back bursts: IDLE is re-entered for exactly one cycle between bursts.

Address update (A-bit, wraps modulo 2^A), with incr = 1<<size:
- FIXED: cur_addr unchanged.
- INCR: cur_addr += incr. The 4KB boundary is not checked.
- WRAP:
  - wrap_bytes = (len+1)<<size.
  - next = (cur_addr & ~(wrap_bytes-1)) | ((cur_addr+incr) & (wrap_bytes-1)).
- The first beat uses the unaligned start address as given; no alignment is applied.

err (latched at pop) is set when any of:
- burst==3
- size > log2(N)
- WRAP with len not in {1,3,7,15}

When err is set, all len+1 beats are returned as SLVERR with no memory accesses.

Optional Feature:
- AXI4_RD_WRAP_BURST_EN defined: WRAP bursts are supported as above.
- Undefined: WRAP sets err, so the whole burst returns SLVERR; the wrap-mask logic is not compiled.

Decomposition:
- Package axi4_rd_engine_pkg:
  - burst encodings FIXED/INCR/WRAP
  - resp encodings OKAY/SLVERR
  - state enum {IDLE, BEAT, WAIT}
- Sub-module axi4_burst_addr_gen: combinational next-address from (cur_addr, burst, size, len). It is reused later by the write-side engine.

Test Plan:
- INCR, araddr=0x100, arlen=3, arsize=3, N=8 -> mem_addr 0x100, 0x108, 0x110, 0x118; 4 R beats OKAY; rlast only on the 4th; rid=arid.
- WRAP, araddr=0x118, arlen=3, arsize=3 (macro defined) -> mem_addr 0x118, 0x100, 0x108, 0x110. With macro undefined -> 4 SLVERR beats, mem_rd_en never asserted.
- FIXED, araddr=0x40, arlen=2 -> mem_addr 0x40 three times; 3 beats; rlast on the 3rd.
- arsize=4 with N=8, arlen=1 -> 2 beats, rresp=2, rdata=0, no mem_rd_en.
- r_wr_full held high 10 cycles mid-INCR burst -> no mem_rd_en while full; beat order and addresses unchanged afterwards; no beat lost.
- aresetn low during WAIT of beat 2 of 4 -> all outputs 0 immediately; a late mem_rd_valid is ignored; the next AR after reset executes normally from beat 0.

Source files
------------

// File: rtl/axi4_rd_engine_pkg.sv
// rtl/axi4_rd_engine_pkg.sv - shared encodings and FSM states for the AXI4 read burst engine
package axi4_rd_engine_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        BEAT,
        WAIT
    } state_e;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// rtl/axi4_burst_addr_gen.sv - combinational AXI4 next-beat address; WRAP support under AXI4_RD_WRAP_BURST_EN
module axi4_burst_addr_gen
    import axi4_rd_engine_pkg::*;
#(
    parameter int A = 32
) (
    input  logic [A-1:0] cur_addr_i,
    input  logic [1:0]   burst_i,
    input  logic [2:0]   size_i,
    input  logic [7:0]   len_i,
    output logic [A-1:0] next_addr_o
);

    logic [A-1:0] incr;
    assign incr = {{(A-1){1'b0}}, 1'b1} << size_i;

`ifdef AXI4_RD_WRAP_BURST_EN
    // Bits below the wrap boundary advance; bits above stay pinned to the wrap window.
    logic [A-1:0] wrap_mask;
    assign wrap_mask = ((A'(len_i) + {{(A-1){1'b0}}, 1'b1}) << size_i) - {{(A-1){1'b0}}, 1'b1};
`else
    logic unused_len;
    assign unused_len = ^len_i;
`endif

    always_comb begin
        next_addr_o = cur_addr_i;
        case (burst_i)
            BURST_FIXED: next_addr_o = cur_addr_i;
            BURST_INCR:  next_addr_o = cur_addr_i + incr;
`ifdef AXI4_RD_WRAP_BURST_EN
            BURST_WRAP:  next_addr_o = (cur_addr_i & ~wrap_mask) | ((cur_addr_i + incr) & wrap_mask);
`endif
            default:     next_addr_o = cur_addr_i;
        endcase
    end

endmodule

// File: rtl/axi4_read_burst_engine.sv
// rtl/axi4_read_burst_engine.sv - AR FIFO to single-beat memory reads to R FIFO; WRAP bursts under AXI4_RD_WRAP_BURST_EN
module axi4_read_burst_engine
    import axi4_rd_engine_pkg::*;
#(
    parameter int A = 32,
    parameter int N = 8,
    parameter int I = 1
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic           ar_rd_empty,
    output logic           ar_rd_en,
    input  logic [A-1:0]   araddr,
    input  logic [1:0]     arburst,
    input  logic [I-1:0]   arid,
    input  logic [7:0]     arlen,
    input  logic [2:0]     arsize,
    input  logic           r_wr_full,
    output logic           r_wr_en,
    output logic [8*N-1:0] rdata,
    output logic [I-1:0]   rid,
    output logic           rlast,
    output logic [1:0]     rresp,
    output logic           mem_rd_en,
    output logic [A-1:0]   mem_addr,
    input  logic [8*N-1:0] mem_rd_data,
    input  logic           mem_rd_valid
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(N));

    state_e       state_q, state_d;
    logic [A-1:0] addr_q, addr_d, next_addr;
    logic [1:0]   burst_q, burst_d;
    logic [I-1:0] id_q, id_d;
    logic [7:0]   len_q, len_d;
    logic [7:0]   beat_cnt_q, beat_cnt_d;
    logic [2:0]   size_q, size_d;
    logic         err_q, err_d;
    logic         wrap_len_ok, ar_err, last_beat;

`ifdef AXI4_RD_WRAP_BURST_EN
    assign wrap_len_ok = (arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15);
`else
    assign wrap_len_ok = 1'b0;
`endif

    assign ar_err = (arburst == 2'd3) || (arsize > MAX_SIZE)
                 || ((arburst == BURST_WRAP) && !wrap_len_ok);

    assign last_beat = (beat_cnt_q == len_q);
    assign rlast     = r_wr_en & last_beat;
    assign rid       = id_q;
    assign mem_addr  = addr_q;

    axi4_burst_addr_gen #(.A(A)) u_addr_gen (
        .cur_addr_i  (addr_q),
        .burst_i     (burst_q),
        .size_i      (size_q),
        .len_i       (len_q),
        .next_addr_o (next_addr)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            burst_q    <= '0;
            id_q       <= '0;
            len_q      <= '0;
            size_q     <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            id_q       <= id_d;
            len_q      <= len_d;
            size_q     <= size_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        burst_d    = burst_q;
        id_d       = id_q;
        len_d      = len_q;
        size_d     = size_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        ar_rd_en   = 1'b0;
        r_wr_en    = 1'b0;
        mem_rd_en  = 1'b0;
        rdata      = '0;
        rresp      = RESP_OKAY;
        case (state_q)
            IDLE: begin
                if (!ar_rd_empty) begin
                    ar_rd_en   = 1'b1;
                    addr_d     = araddr;
                    burst_d    = arburst;
                    id_d       = arid;
                    len_d      = arlen;
                    size_d     = arsize;
                    beat_cnt_d = 8'd0;
                    err_d      = ar_err;
                    state_d    = BEAT;
                end
            end
            BEAT: begin
                // Errored bursts still return every beat, just without touching memory.
                if (!r_wr_full) begin
                    if (err_q) begin
                        r_wr_en    = 1'b1;
                        rresp      = RESP_SLVERR;
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        if (last_beat) state_d = IDLE;
                    end else begin
                        mem_rd_en = 1'b1;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rd_valid) begin
                    r_wr_en    = 1'b1;
                    rdata      = mem_rd_data;
                    addr_d     = next_addr;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    state_d    = last_beat ? IDLE : BEAT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_read_burst_engine.sv
// tb/tb_axi4_read_burst_engine.sv - scoreboard bench for axi4_read_burst_engine
module tb_axi4_read_burst_engine;
    import axi4_rd_engine_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        ar_rd_empty = 1'b1;
    logic        ar_rd_en;
    logic [31:0] araddr = '0;
    logic [1:0]  arburst = '0;
    logic [0:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic        r_wr_full;
    logic        r_wr_en;
    logic [63:0] rdata;
    logic [0:0]  rid;
    logic        rlast;
    logic [1:0]  rresp;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [63:0] mem_rd_data;
    logic        mem_rd_valid;

    always #5 aclk = ~aclk;

    axi4_read_burst_engine #(.A(32), .N(8), .I(1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .ar_rd_empty(ar_rd_empty), .ar_rd_en(ar_rd_en), .araddr(araddr), .arburst(arburst),
        .arid(arid), .arlen(arlen), .arsize(arsize),
        .r_wr_full(r_wr_full), .r_wr_en(r_wr_en), .rdata(rdata), .rid(rid), .rlast(rlast), .rresp(rresp),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid)
    );

    typedef struct packed {
        logic [1:0]  burst;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic        id;
    } ar_t;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        id;
    } beat_t;

    ar_t         ar_fifo[$];
    beat_t       exp_q[$];
    logic [31:0] exp_addr_q[$];

    int   checks = 0;
    int   failures = 0;
    int   nbeats = 0;
    int   nreads = 0;
    int   mem_lat_fixed = 0;
    logic end_chk = 1'b0;
    logic stray_valid = 1'b0;

    logic        mem_valid_r = 1'b0;
    logic [63:0] mem_data_r = '0;
    logic        pend = 1'b0;
    logic [31:0] paddr = '0;
    int          cnt = 0;

    assign mem_rd_valid = mem_valid_r | stray_valid;
    assign mem_rd_data  = mem_data_r;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a, ~a};
    endfunction

    // AR FIFO and memory model: sample DUT requests at the edge, drive responses 1 ns later.
    always @(posedge aclk) begin
        logic        pop;
        logic        req;
        logic [31:0] ra;
        pop = ar_rd_en;
        req = mem_rd_en;
        ra  = mem_addr;
        #1;
        if (pop && ar_fifo.size() != 0) void'(ar_fifo.pop_front());
        mem_valid_r = 1'b0;
        if (!aresetn) begin
            pend = 1'b0;
        end else begin
            if (req) begin
                pend  = 1'b1;
                paddr = ra;
                cnt   = (mem_lat_fixed > 0) ? mem_lat_fixed : int'($urandom_range(1, 3));
            end
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    mem_valid_r = 1'b1;
                    mem_data_r  = mem_word(paddr);
                    pend        = 1'b0;
                end
            end
        end
        ar_rd_empty = (ar_fifo.size() == 0);
        if (!ar_rd_empty) begin
            araddr  = ar_fifo[0].addr;
            arburst = ar_fifo[0].burst;
            arid    = ar_fifo[0].id;
            arlen   = ar_fifo[0].len;
            arsize  = ar_fifo[0].size;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (!aresetn) begin
            chk("rst_ctrl", 128'({ar_rd_en, r_wr_en, mem_rd_en, rlast}), 128'd0);
            chk("rst_data", 128'({rdata, rid, rresp, mem_addr}), 128'd0);
            exp_q.delete();
            exp_addr_q.delete();
        end else begin
            if (mem_rd_en) begin
                nreads++;
                chk("mem_rd_while_full", 128'(r_wr_full), 128'd0);
                chk("mem_rd_expected", 128'(exp_addr_q.size() != 0), 128'd1);
                if (exp_addr_q.size() != 0) chk("mem_addr", 128'(mem_addr), 128'(exp_addr_q.pop_front()));
            end
            if (r_wr_en) begin
                nbeats++;
                chk("r_beat_expected", 128'(exp_q.size() != 0), 128'd1);
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("rdata", 128'(rdata), 128'(e.data));
                    chk("rresp", 128'(rresp), 128'(e.resp));
                    chk("rlast", 128'(rlast), 128'(e.last));
                    chk("rid", 128'(rid), 128'(e.id));
                end
            end
            if (end_chk) begin
                chk("sb_beats_left", 128'(exp_q.size()), 128'd0);
                chk("sb_addrs_left", 128'(exp_addr_q.size()), 128'd0);
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    task automatic send_ar(input logic [1:0] b, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic id);
        logic        err;
        logic        wrap_en;
        logic [31:0] incr, wb, base, ad;
`ifdef AXI4_RD_WRAP_BURST_EN
        wrap_en = 1'b1;
`else
        wrap_en = 1'b0;
`endif
        err  = (b == 2'd3) || (size > 3'd3)
            || (b == 2'd2 && !(wrap_en && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)));
        incr = 32'd1 << size;
        wb   = (32'(len) + 32'd1) << size;
        base = a & ~(wb - 32'd1);
        for (int k = 0; k <= int'(len); k++) begin
            case (b)
                2'd0:    ad = a;
                2'd1:    ad = a + 32'(k) * incr;
                default: ad = base + ((a - base + 32'(k) * incr) % wb);
            endcase
            if (!err) exp_addr_q.push_back(ad);
            exp_q.push_back('{data: err ? 64'h0 : mem_word(ad), resp: err ? 2'd2 : 2'd0,
                              last: (k == int'(len)), id: id});
        end
        ar_fifo.push_back('{burst: b, addr: a, len: len, size: size, id: id});
    endtask

    task automatic run_to_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ar_fifo.size() != 0) && n < 400) begin
            step();
            n++;
        end
        step();
        end_chk = 1'b1;
        step();
        end_chk = 1'b0;
    endtask

    initial begin
        int base_cnt;
        int n;
        aresetn   = 1'b0;
        r_wr_full = 1'b0;
        repeat (3) step();
        aresetn = 1'b1;
        step();

        send_ar(BURST_INCR, 32'h100, 8'd3, 3'd3, 1'b1);
        run_to_done();
        send_ar(BURST_WRAP, 32'h118, 8'd3, 3'd3, 1'b0);
        run_to_done();
        send_ar(BURST_FIXED, 32'h40, 8'd2, 3'd3, 1'b1);
        run_to_done();
        send_ar(BURST_INCR, 32'h200, 8'd1, 3'd4, 1'b0);
        run_to_done();
        send_ar(2'd3, 32'h300, 8'd0, 3'd2, 1'b1);
        run_to_done();
        send_ar(BURST_WRAP, 32'h400, 8'd2, 3'd2, 1'b0);
        run_to_done();

        send_ar(BURST_INCR, 32'h500, 8'd1, 3'd3, 1'b1);
        send_ar(BURST_FIXED, 32'h600, 8'd0, 3'd3, 1'b0);
        run_to_done();

        mem_lat_fixed = 1;
        base_cnt = nbeats;
        send_ar(BURST_INCR, 32'h1000, 8'd7, 3'd3, 1'b1);
        n = 0;
        while (nbeats < base_cnt + 2 && n < 100) begin
            step();
            n++;
        end
        r_wr_full = 1'b1;
        repeat (10) step();
        r_wr_full = 1'b0;
        run_to_done();

        mem_lat_fixed = 4;
        base_cnt = nreads;
        send_ar(BURST_INCR, 32'h2000, 8'd3, 3'd3, 1'b0);
        n = 0;
        while (nreads < base_cnt + 2 && n < 100) begin
            step();
            n++;
        end
        aresetn = 1'b0;
        repeat (2) step();
        aresetn = 1'b1;
        step();
        stray_valid = 1'b1;
        step();
        stray_valid = 1'b0;
        run_to_done();

        mem_lat_fixed = 0;
        send_ar(BURST_INCR, 32'h80, 8'd1, 3'd2, 1'b1);
        run_to_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
